// File: rtl/pc_uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, one sample per bit at mid-bit.
// Emits each good byte with a one-cycle rx_valid strobe; a low stop bit gives a one-cycle frame_err.
module pc_uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_rx_data;
   logic            r_rx_valid;
   logic            r_frame_err;
   logic            r_sync1;
   logic            r_rx_s;

   // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments here let both flops sample the old values on the same edge,
         // which is what makes this a two-stage synchronizer rather than a single wire.
         r_sync1 <= rx_in;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every state register, including the shift register, is reset so no stale partial
         // byte can ever leak out after a mid-frame reset.
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (!r_rx_s) r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == BIT_M1) begin
                  r_cnt              <= '0;
                  r_shift[r_bit_idx] <= r_rx_s;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == BIT_M1) begin
                  r_cnt <= '0;
                  // Leaving at mid-stop-bit gives half a bit of slack for a back-to-back start edge.
                  if (r_rx_s) begin
                     r_rx_data  <= r_shift;
                     r_rx_valid <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_BREAK: begin
               r_cnt <= '0;
               if (r_rx_s) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pc_uart_rx.sv
// Bench for pc_uart_rx: table of frames driven on the pin, expected strobes queued in a scoreboard
// and matched (data, kind, exact cycle) when the receiver pulses.
module tb_pc_uart_rx;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;
   // pin edge -> 2 sync flops -> detect edge E0, then HALF + 9 bits to the stop sample, then one register
   localparam int LAT  = 3 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   pc_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_in    (rx_in),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold_low;
      int         gap;
   } vec_t;

   exp_t       sb[$];
   logic [7:0] model_data = 8'h00;
   exp_t       mon_e;

   // Monitor: every strobe must match the oldest queued expectation, at the predicted cycle.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || frame_err)) begin
         check("valid_err_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {31'b0, frame_err}, {31'b0, rx_valid});
            check("unexpected_pulse_count", 32'd1, 32'd0 + sb.size());
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind_err", {31'b0, frame_err}, {31'b0, mon_e.err});
            check("pulse_cycle", cyc, mon_e.cyc);
            if (!mon_e.err) begin
               check("rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
               model_data = mon_e.data;
               check("busy_after_valid", {31'b0, busy}, 32'd0);
            end else begin
               check("rx_data_held_on_err", {24'b0, rx_data}, {24'b0, model_data});
               check("busy_in_break", {31'b0, busy}, 32'd1);
            end
         end
      end
   end

   // Caller must be at a negedge; the frame occupies exactly 10*CPB cycles so frames can abut.
   task automatic drive_frame(input vec_t v);
      logic [9:0] f;
      exp_t       e;
      f      = {v.stop, v.data, 1'b0};
      e.data = v.data;
      e.err  = ~v.stop;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
      for (int b = 0; b < 10; b++) begin
         rx_in = f[b];
         repeat (CPB) @(negedge clk);
      end
      if (v.hold_low > 0) begin
         rx_in = 1'b0;
         repeat (v.hold_low) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (v.gap) @(negedge clk);
   endtask

   task automatic glitch_seq();
      logic saw_busy;
      saw_busy = 1'b0;
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("glitch_busy_seen", {31'b0, saw_busy}, 32'd1);
      check("glitch_back_to_idle", {31'b0, busy}, 32'd0);
   endtask

   task automatic reset_mid_frame_seq();
      logic [9:0] f;
      f = {1'b1, 8'hC3, 1'b0};
      for (int b = 0; b < 4; b++) begin
         rx_in = f[b];
         repeat (CPB) @(negedge clk);
      end
      rx_in = f[4];
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_data = 8'h00;
      check("rst_mid_rx_data", {24'b0, rx_data}, 32'd0);
      check("rst_mid_rx_valid", {31'b0, rx_valid}, 32'd0);
      check("rst_mid_frame_err", {31'b0, frame_err}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_release_idle", {31'b0, busy}, 32'd0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{data: 8'hA5, stop: 1'b1, hold_low: 0,  gap: 10};
      vecs[1] = '{data: 8'h3C, stop: 1'b1, hold_low: 0,  gap: 5};
      vecs[2] = '{data: 8'h5A, stop: 1'b0, hold_low: 30, gap: 10};
      vecs[3] = '{data: 8'h3C, stop: 1'b1, hold_low: 0,  gap: 10};
      vecs[4] = '{data: 8'h00, stop: 1'b1, hold_low: 0,  gap: 0};
      vecs[5] = '{data: 8'hFF, stop: 1'b1, hold_low: 0,  gap: 10};
      vecs[6] = '{data: 8'h81, stop: 1'b1, hold_low: 0,  gap: 10};
      vecs[7] = '{data: 8'h01, stop: 1'b1, hold_low: 0,  gap: 3};
      vecs[8] = '{data: 8'h80, stop: 1'b1, hold_low: 0,  gap: 20};

      repeat (3) @(negedge clk);
      check("reset_rx_data", {24'b0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         if (i == 1) glitch_seq();
         if (i == 6) reset_mid_frame_seq();
         drive_frame(vecs[i]);
      end

      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      check("final_rx_data", {24'b0, rx_data}, 32'h80);
      check("final_idle", {31'b0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
